// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer, flag and level control for an asynchronous FIFO
//   WCLK         write-domain clock, rising edge
//   WRST         asynchronous active-low reset
//   winc         write request, data accepted on the same edge
//   rptr_gray    Gray read pointer from the read domain (asynchronous)
//   wclk_en      memory write enable
//   waddr        memory write address
//   wptr_gray    registered Gray write pointer to the read domain
//   wfull        FIFO full
//   walmost_full level >= DEPTH-AF_MARGIN
//   wlevel       write-side occupancy 0..DEPTH
//   woverflow    sticky, set by a write attempt while full
module fifo_wr_ctrl #(
  parameter int DEPTH = 16,
  parameter int AF_MARGIN = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          WCLK,
  input  logic          WRST,
  input  logic          winc,
  input  logic [AW:0]   rptr_gray,
  output logic          wclk_en,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wptr_gray,
  output logic          wfull,
  output logic          walmost_full,
  output logic [AW:0]   wlevel,
  output logic          woverflow
);
  localparam logic [AW:0] AF_TH = (AW+1)'(DEPTH - AF_MARGIN);
  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d, rq1_q, rq2_q, rbin_sync, level_q, level_d;
  logic full_q, full_d, af_q, af_d, ovf_q, ovf_d;
  // Reset gating keeps the memory from being written while WRST is low,
  // since the cleared full flag would otherwise let winc through.
  assign wclk_en = winc & ~full_q & WRST;
  assign waddr = wbin_q[AW-1:0];
  assign wbin_d = wbin_q + (AW+1)'(wclk_en);
  assign wgray_d = (wbin_d >> 1) ^ wbin_d;
  // Full: write pointer is exactly one lap ahead of the synchronized read pointer.
  assign full_d = wgray_d == {~rq2_q[AW:AW-1], rq2_q[AW-2:0]};
  for (genvar i = 0; i <= AW; i++) begin : g_g2b
    assign rbin_sync[i] = ^rq2_q[AW:i];
  end
  assign level_d = wbin_d - rbin_sync;
  assign af_d = level_d >= AF_TH;
  assign ovf_d = ovf_q | (winc & full_q);
  always_ff @(posedge WCLK or negedge WRST) begin
    if (!WRST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rptr_gray;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end
  assign wptr_gray = wgray_q;
  assign wfull = full_q;
  assign walmost_full = af_q;
  assign wlevel = level_q;
  assign woverflow = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: randomized scoreboard bench for fifo_wr_ctrl against an occupancy-count model
module tb_fifo_wr_ctrl;
  localparam int DEPTH = 16;
  localparam int AF = 2;
  localparam int AW = 4;
  logic WCLK = 0, WRST = 0, winc = 1;
  logic [AW:0] rptr_gray = '0;
  logic wclk_en, wfull, walmost_full, woverflow;
  logic [AW-1:0] waddr;
  logic [AW:0] wptr_gray, wlevel;
  fifo_wr_ctrl #(.DEPTH(DEPTH), .AF_MARGIN(AF)) dut (
    .WCLK(WCLK), .WRST(WRST), .winc(winc), .rptr_gray(rptr_gray),
    .wclk_en(wclk_en), .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );
  always #5 WCLK = ~WCLK;
  typedef struct {
    logic en;
    logic [AW-1:0] addr;
    logic full, af;
    logic [AW:0] level;
    logic ovf;
    logic [AW:0] gray;
    bit first;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int wcnt, rcnt, p1, p2, m_level;
  bit m_ovf, first;
  function automatic logic [AW:0] gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    wcnt = 0; rcnt = 0; p1 = 0; p2 = 0; m_level = 0; m_ovf = 0; first = 1;
  endtask
  task automatic rst_checks(input string tag);
    chk({tag, "_wclk_en"}, 32'(wclk_en), 0);
    chk({tag, "_waddr"}, 32'(waddr), 0);
    chk({tag, "_wptr_gray"}, 32'(wptr_gray), 0);
    chk({tag, "_wfull"}, 32'(wfull), 0);
    chk({tag, "_walmost_full"}, 32'(walmost_full), 0);
    chk({tag, "_wlevel"}, 32'(wlevel), 0);
    chk({tag, "_woverflow"}, 32'(woverflow), 0);
  endtask
  // One write-clock cycle: drive inputs, queue the expected view for this cycle,
  // then advance the model across the closing edge. The write side sees the read
  // count that was driven two cycles earlier.
  task automatic cycle(input bit w, input int rd, input bit rel = 0);
    exp_t e;
    @(posedge WCLK);
    #1;
    if (rel) WRST = 1;
    for (int i = 0; i < rd; i++) if (rcnt < wcnt) rcnt++;
    winc = w;
    rptr_gray = gray(rcnt);
    e.full = m_level == DEPTH;
    e.en = w && !e.full;
    e.addr = AW'(wcnt % DEPTH);
    e.af = m_level >= DEPTH - AF;
    e.level = (AW+1)'(m_level);
    e.ovf = m_ovf;
    e.gray = gray(wcnt);
    e.first = first;
    first = 0;
    q.push_back(e);
    if (e.en) wcnt++;
    if (w && e.full) m_ovf = 1;
    m_level = wcnt - p2;
    p2 = p1;
    p1 = rcnt;
  endtask
  initial begin : monitor
    exp_t e;
    logic [AW:0] pe, pa;
    pe = '0;
    pa = '0;
    forever begin
      @(negedge WCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wclk_en", 32'(wclk_en), 32'(e.en));
        chk("waddr", 32'(waddr), 32'(e.addr));
        chk("wfull", 32'(wfull), 32'(e.full));
        chk("walmost_full", 32'(walmost_full), 32'(e.af));
        chk("wlevel", 32'(wlevel), 32'(e.level));
        chk("woverflow", 32'(woverflow), 32'(e.ovf));
        chk("wptr_gray", 32'(wptr_gray), 32'(e.gray));
        if (!e.first && e.gray != pe) chk("gray_hamming", 32'($countones(wptr_gray ^ pa)), 1);
        pe = e.gray;
        pa = wptr_gray;
      end
    end
  end
  initial begin
    model_reset();
    #1;
    rst_checks("rst_init");
    repeat (2) @(negedge WCLK);
    rst_checks("rst_held");
    cycle(1, 0, 1);
    repeat (15) cycle(1, 0);
    repeat (3) cycle(0, 0);
    cycle(1, 0);
    repeat (3) cycle(0, 0);
    cycle(0, 3);
    repeat (4) cycle(0, 0);
    repeat (2) cycle(1, 0);
    cycle(0, 0);
    cycle(1, 1);
    repeat (5) cycle(0, 0);
    for (int i = 0; i < 400; i++) cycle(1'($urandom_range(0, 1)), $urandom_range(0, 1));
    repeat (4) cycle(0, 1);
    repeat (3) cycle(1, 0);
    @(negedge WCLK);
    #1;
    winc = 1;
    WRST = 0;
    #1;
    rst_checks("rst_mid");
    model_reset();
    rptr_gray = '0;
    repeat (2) @(negedge WCLK);
    rst_checks("rst_mid_held");
    cycle(1, 0, 1);
    repeat (5) cycle(1, 0);
    repeat (3) cycle(0, 1);
    repeat (2) @(negedge WCLK);
    chk("sb_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
